ysyx_24100027_ifu: RTL and testbench

Instruction fetch unit that sits directly upstream of the single-cycle CPU core. It holds the architectural PC and fetches one 32-bit instruction per PC over a valid/ready instruction-memory port. It presents each `pc`/`inst` pair to the core under a valid/ready handshake. When the core consumes an instruction, it returns the next-PC decision (sequential or redirect), and the IFU updates the PC from that decision.

---
 rtl/ysyx_24100027_pkg.sv | 15 +
 rtl/ysyx_24100027_pc_reg.sv | 58 +++++
 rtl/ysyx_24100027_ifu.sv | 106 ++++++++++
 tb/tb_ysyx_24100027_ifu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100027_pkg.sv
// Shared definitions for the ysyx_24100027 instruction fetch unit:
// FSM state encoding, the reset instruction word and the sequential PC step.
package ysyx_24100027_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } ifu_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/ysyx_24100027_pc_reg.sv
// Architectural PC register with synchronous reset to RESET_PC, a load
// enable and a sequential/redirect next-PC select.
// YSYX_24100027_IFU_ALIGN_CHECK_EN defined: a redirect target is loaded
// unmodified and misaligned_o flags a target with non-zero low bits.
// Undefined: the two low bits of a redirect target are cleared on load.
module ysyx_24100027_pc_reg
  import ysyx_24100027_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
`ifdef YSYX_24100027_IFU_ALIGN_CHECK_EN
  output logic        misaligned_o,
`endif
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] target;

`ifdef YSYX_24100027_IFU_ALIGN_CHECK_EN
  // Keep the raw target so a faulting PC is visible for debug.
  assign target       = redirect_pc_i;
  assign misaligned_o = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
  // Silently word-align redirect targets.
  assign target = redirect_pc_i & ~32'h0000_0003;
`endif

  // Next-PC select: hold, step by one word (modular wrap), or redirect.
  // NOTE: every variable written in always_comb gets a default first so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = redirect_i ? target : (pc_q + PC_STEP);
    end
  end

  // PC state register with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per PC over a
// valid/ready memory port and presents pc/inst to the core under a
// valid/ready handshake. All outputs decode from registers.
// Optional feature macro: YSYX_24100027_IFU_ALIGN_CHECK_EN (misaligned
// redirect goes to a sticky fault state instead of being word-aligned).
module ysyx_24100027_ifu
  import ysyx_24100027_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  ifu_state_e  state_q;
  ifu_state_e  state_d;
  logic [31:0] inst_q;
  logic [31:0] inst_d;
  logic        pc_load;
  logic [31:0] pc_w;
`ifdef YSYX_24100027_IFU_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  // The PC only moves when the core accepts the presented instruction.
  assign pc_load = (state_q == S_VALID) && out_ready;

  ysyx_24100027_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .load_i        (pc_load),
    .redirect_i    (redirect_valid),
    .redirect_pc_i (redirect_pc),
`ifdef YSYX_24100027_IFU_ALIGN_CHECK_EN
    .misaligned_o  (misaligned),
`endif
    .pc_o          (pc_w)
  );

  // Next-state and instruction-capture logic.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (out_ready) begin
`ifdef YSYX_24100027_IFU_ALIGN_CHECK_EN
          state_d = misaligned ? S_FAULT : S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
`ifdef YSYX_24100027_IFU_ALIGN_CHECK_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_REQ;
    endcase
  end

  // State and instruction registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      inst_q  <= INST_NOP;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign out_valid      = (state_q == S_VALID);
  assign imem_addr      = pc_w;
  assign pc             = pc_w;
  assign inst           = inst_q;
`ifdef YSYX_24100027_IFU_ALIGN_CHECK_EN
  assign fault          = (state_q == S_FAULT);
`else
  assign fault          = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24100027_ifu.sv
// Self-checking bench for ysyx_24100027_ifu. Inputs change and outputs are
// sampled on the falling edge; a transaction-level model tracks the PC the
// IFU should be fetching and the instruction it should be presenting.
module tb_ysyx_24100027_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic        exp_fault;

  ysyx_24100027_ifu #(
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc             (pc),
    .inst           (inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One full fetch: request stalled req_dly cycles, response delayed rsp_dly
  // cycles past the earliest slot, output back-pressured bp_dly cycles, then
  // consumed with the given next-PC decision. Entered and left in the
  // request phase (falling edge).
  task automatic fetch_one(input int req_dly, input int rsp_dly, input int bp_dly,
                           input logic [31:0] data, input logic redir,
                           input logic [31:0] rpc);
    check("req_valid", imem_req_valid, 1'b1);
    check("req_addr", imem_addr, exp_pc);
    check("req_no_out", out_valid, 1'b0);
    for (int k = 0; k < req_dly; k++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;            // must be ignored while requesting
      imem_rsp_data  = $urandom;
      step();
      check("stall_req_valid", imem_req_valid, 1'b1);
      check("stall_addr", imem_addr, exp_pc);
      check("stall_inst", inst, exp_inst);
    end
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    step();
    imem_req_ready = 1'b0;
    check("wait_no_req", imem_req_valid, 1'b0);
    check("wait_no_out", out_valid, 1'b0);
    for (int k = 0; k < rsp_dly; k++) begin
      imem_rsp_data = $urandom;
      step();
      check("rspdly_no_out", out_valid, 1'b0);
      check("rspdly_inst", inst, exp_inst);
      check("rspdly_addr", imem_addr, exp_pc);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    exp_inst = data;
    check("out_valid", out_valid, 1'b1);
    check("out_pc", pc, exp_pc);
    check("out_inst", inst, exp_inst);
    for (int k = 0; k < bp_dly; k++) begin
      out_ready      = 1'b0;
      redirect_valid = $urandom_range(0, 1);  // no handshake: ignored
      redirect_pc    = $urandom;
      imem_rsp_valid = 1'b1;                  // ignored while presenting
      imem_rsp_data  = $urandom;
      step();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_no_req", imem_req_valid, 1'b0);
      check("bp_pc", pc, exp_pc);
      check("bp_inst", inst, exp_inst);
    end
    imem_rsp_valid = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (!redir) begin
      exp_pc = exp_pc + 32'd4;
    end else begin
`ifdef YSYX_24100027_IFU_ALIGN_CHECK_EN
      exp_pc = rpc;
      if (rpc[1:0] != 2'b00) exp_fault = 1'b1;
`else
      exp_pc = {rpc[31:2], 2'b00};
`endif
    end
    step();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    check("next_fault", fault, exp_fault);
    check("next_pc", pc, exp_pc);
    check("next_out_valid", out_valid, 1'b0);
    check("next_req_valid", imem_req_valid, !exp_fault);
    check("next_addr", imem_addr, exp_pc);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] rpc;
    logic        redir;

    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    exp_pc         = RESET_PC;
    exp_inst       = NOP;
    exp_fault      = 1'b0;

    repeat (3) step();
    check("rst_req_valid", imem_req_valid, 1'b1);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, NOP);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_fault", fault, 1'b0);
    rst = 1'b0;
    step();

    // Zero-wait memory, always-ready core: one instruction per 3 cycles.
    repeat (3) fetch_one(0, 0, 0, NOP, 1'b0, 32'h0);

    // Slow memory: request stalled 4 cycles, response 5 cycles late.
    fetch_one(4, 5, 0, 32'hDEAD_BEEF, 1'b0, 32'h0);

    // Core back-pressure for 10 cycles with stray redirects, then release.
    fetch_one(0, 0, 10, 32'h1234_5678, 1'b0, 32'h0);

    // Redirect on handshake.
    fetch_one(0, 0, 0, 32'h0000_006F, 1'b1, 32'h8000_0100);

    // Modular wrap of the sequential PC.
    fetch_one(0, 0, 0, 32'hAAAA_5555, 1'b1, 32'hFFFF_FFFC);
    fetch_one(0, 0, 0, 32'h5555_AAAA, 1'b0, 32'h0);

    // Reset while waiting for the response.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("rw_in_wait", imem_req_valid, 1'b0);
    rst            = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    step();
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;
    exp_pc         = RESET_PC;
    exp_inst       = NOP;
    check("rw_req_valid", imem_req_valid, 1'b1);
    check("rw_addr", imem_addr, RESET_PC);
    check("rw_out_valid", out_valid, 1'b0);
    check("rw_inst", inst, NOP);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      d     = $urandom;
      redir = ($urandom_range(0, 3) == 0);
      rpc   = $urandom;
`ifdef YSYX_24100027_IFU_ALIGN_CHECK_EN
      rpc   = {rpc[31:2], 2'b00};
`endif
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                d, redir, rpc);
    end

    // Misaligned redirect.
    fetch_one(0, 0, 0, 32'h0000_0013, 1'b1, 32'h8000_0102);
`ifdef YSYX_24100027_IFU_ALIGN_CHECK_EN
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("flt_sticky", fault, 1'b1);
      check("flt_no_req", imem_req_valid, 1'b0);
      check("flt_no_out", out_valid, 1'b0);
      check("flt_pc", pc, 32'h8000_0102);
    end
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
`else
    check("mis_aligned_addr", imem_addr, 32'h8000_0100);
    fetch_one(0, 0, 0, 32'h0000_0013, 1'b0, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
